// File: rtl/fw_pkg.sv
// Shared constants and types for the fw output-stream drain.
package fw_pkg;

  localparam int unsigned DATA_W         = 64;
  localparam int unsigned ELEM_W         = 16;
  localparam int unsigned TILE_DIM       = 8;
  // 8x8 elements of ELEM_W bits packed DATA_W/ELEM_W per word -> 16 words
  localparam int unsigned WORDS_PER_TILE = TILE_DIM * TILE_DIM * ELEM_W / DATA_W;
  localparam int unsigned TILE_CNT_W     = 8;
  localparam int unsigned ADDR_W         = $clog2(WORDS_PER_TILE);

  typedef logic [DATA_W-1:0] fw_word_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } drain_state_t;

endpackage

// File: rtl/fw_tile_bank.sv
// Ping-pong tile storage: 2 banks x WORDS_PER_TILE words, addressed by
// {bank, word}. Synchronous write, synchronous registered read; the read
// register holds its value whenever no read is issued.
module fw_tile_bank
  import fw_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_we,
  input  logic [ADDR_W:0] i_waddr,
  input  fw_word_t        i_wdata,
  input  logic            i_re,
  input  logic [ADDR_W:0] i_raddr,
  output fw_word_t        o_rdata
);

  fw_word_t r_mem [2*WORDS_PER_TILE];
  fw_word_t r_rdata;

  // Storage array write port (no reset on the array itself).
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port; cleared by reset so the stream output reads 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fw_tile_drain.sv
// Receives fw result words into ping-pong tile banks and streams each
// completed tile to a valid/ready consumer, throttling fw via inhibit.
module fw_tile_drain
  import fw_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     inD,
  input  logic                  in_valid,
  output logic                  inhibit,
  output logic [DATA_W-1:0]     outD,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [TILE_CNT_W-1:0] out_tile,
  output logic                  overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_TILE - 1);

  drain_state_t          r_state;
  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_addr;
  logic                  r_out_valid;
  logic [TILE_CNT_W-1:0] r_tile;
  logic                  r_overflow;

  logic                  w_hs;
  logic                  w_last;
  logic                  w_release;
  logic                  w_wr_free;
  logic                  w_we;
  logic                  w_drop;
  logic                  w_wr_done;
  logic                  w_re;
  logic [ADDR_W:0]       w_raddr;
  fw_word_t              w_rdata;

  assign w_hs      = r_out_valid && out_ready;
  assign w_last    = r_out_valid && (r_rd_addr == LAST_ADDR);
  assign w_release = w_hs && w_last;
  // A full write bank still takes a word if the reader frees it this edge.
  assign w_wr_free = !r_full[r_wr_bank] || (w_release && (r_rd_bank == r_wr_bank));
  assign w_we      = in_valid && w_wr_free;
  assign w_drop    = in_valid && !w_wr_free;
  assign w_wr_done = w_we && (r_wr_ptr == LAST_ADDR);

  // Read address: word 0 in LOAD, next word on each non-final handshake.
  always_comb begin
    w_re    = 1'b0;
    w_raddr = {r_rd_bank, r_rd_addr};
    if (r_state == LOAD) begin
      w_re    = 1'b1;
      w_raddr = {r_rd_bank, {ADDR_W{1'b0}}};
    end else if ((r_state == STREAM) && w_hs && !w_last) begin
      w_re    = 1'b1;
      w_raddr = {r_rd_bank, r_rd_addr + 1'b1};
    end
  end

  fw_tile_bank u_bank (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_we    (w_we),
    .i_waddr ({r_wr_bank, r_wr_ptr}),
    .i_wdata (inD),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Write pointer/bank advance and sticky overflow on dropped words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_bank  <= 1'b0;
      r_wr_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_we) begin
        if (w_wr_done) begin
          r_wr_ptr  <= '0;
          r_wr_bank <= !r_wr_bank;
        end else begin
          r_wr_ptr  <= r_wr_ptr + 1'b1;
        end
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Bank-full flags: set on the final write of a tile, cleared on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= '0;
    end else begin
      if (w_release) r_full[r_rd_bank] <= 1'b0;
      if (w_wr_done) r_full[r_wr_bank] <= 1'b1;
    end
  end

  // Read FSM: wait for a full bank, prime the read, then stream the tile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rd_bank   <= 1'b0;
      r_rd_addr   <= '0;
      r_out_valid <= 1'b0;
      r_tile      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_full[r_rd_bank]) r_state <= LOAD;
        end
        LOAD: begin
          r_rd_addr   <= '0;
          r_out_valid <= 1'b1;
          r_state     <= STREAM;
        end
        STREAM: begin
          if (w_hs) begin
            if (w_last) begin
              r_out_valid <= 1'b0;
              r_rd_addr   <= '0;
              r_rd_bank   <= !r_rd_bank;
              r_tile      <= r_tile + 1'b1;
              r_state     <= r_full[!r_rd_bank] ? LOAD : IDLE;
            end else begin
              r_rd_addr   <= r_rd_addr + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign inhibit   = r_full[r_wr_bank];
  assign outD      = w_rdata;
  assign out_valid = r_out_valid;
  assign out_last  = w_last;
  assign out_addr  = r_rd_addr;
  assign out_tile  = r_tile;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fw_tile_drain.sv
// Directed bench for fw_tile_drain: scoreboard of accepted words, stream
// monitor on the falling edge, hand-computed flag and counter expectations.
module tb_fw_tile_drain;
  import fw_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [DATA_W-1:0]     inD;
  logic                  in_valid;
  logic                  inhibit;
  logic [DATA_W-1:0]     outD;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [3:0]            out_addr;
  logic [TILE_CNT_W-1:0] out_tile;
  logic                  overflow;

  always #5 clk = ~clk;

  fw_tile_drain dut (
    .clk       (clk),
    .reset     (reset),
    .inD       (inD),
    .in_valid  (in_valid),
    .inhibit   (inhibit),
    .outD      (outD),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_addr  (out_addr),
    .out_tile  (out_tile),
    .overflow  (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [63:0] exp_q[$];
  int          hs_cyc[$];
  int          delivered = 0;
  int          idx       = 0;
  int          cyc       = 0;
  int          n_stall   = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_outD;
  logic [3:0]  prev_addr;

  function automatic logic [63:0] gen_word(input int t, input int i);
    if (t == 0 && i == 0) return 64'h0061_0047_003f_0000;
    if (t == 0 && i == 1) return 64'h0055_001a_0006_0052;
    return {16'(t + 1), 16'(i), 16'(t * 37 + i * 5 + 3), 16'(32'hc3a0 ^ (t * 16 + i))};
  endfunction

  // Stream monitor: handshakes resolve on the next rising edge, so the
  // falling-edge view is exactly what the DUT will transfer.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      idx        = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_stall++;
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_outD", outD, prev_outD);
        check("hold_addr", 64'(out_addr), 64'(prev_addr));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", outD, 64'd0 - 64'd1);
        end else begin
          check("outD", outD, exp_q.pop_front());
        end
        check("out_addr", 64'(out_addr), 64'(idx));
        check("out_last", 64'(out_last), 64'(idx == 15));
        delivered++;
        hs_cyc.push_back(cyc);
        idx = (idx + 1) % 16;
      end
      prev_stall = out_valid && !out_ready;
      prev_outD  = outD;
      prev_addr  = out_addr;
    end
  end

  task automatic send(input logic [63:0] w, input bit acc);
    inD      = w;
    in_valid = 1'b1;
    if (acc) exp_q.push_back(w);
    @(posedge clk); #1;
    in_valid = 1'b0;
    inD      = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    hs_cyc.delete();
    delivered = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_drained(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(n >= budget), 64'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_inhibit"},   64'(inhibit),   64'd0);
    check({tag, "_outD"},      outD,           64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_last"},  64'(out_last),  64'd0);
    check({tag, "_out_addr"},  64'(out_addr),  64'd0);
    check({tag, "_out_tile"},  64'(out_tile),  64'd0);
    check({tag, "_overflow"},  64'(overflow),  64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    inD       = '0;
    out_ready = 1'b1;
    #2;
    check_zero_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: single tile, consumer always ready; out_valid 2 cycles after word 15
    for (int i = 0; i < 16; i++) begin
      send(gen_word(0, i), 1'b1);
      check("t1_inhibit", 64'(inhibit), 64'd0);
    end
    check("t1_lat0", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("t1_lat1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("t1_lat2", 64'(out_valid), 64'd1);
    wait_drained("t1_drain_timeout", 100);
    check("t1_tile", 64'(out_tile), 64'd1);
    check("t1_count", 64'(delivered), 64'd16);
    check("t1_overflow", 64'(overflow), 64'd0);

    // 2: two tiles back to back, one bubble between them
    do_reset();
    for (int i = 0; i < 32; i++) send(gen_word(1 + i / 16, i % 16), 1'b1);
    wait_drained("t2_drain_timeout", 200);
    check("t2_tile", 64'(out_tile), 64'd2);
    check("t2_count", 64'(delivered), 64'd32);
    check("t2_overflow", 64'(overflow), 64'd0);
    g = (hs_cyc.size() >= 32) ? hs_cyc[15] - hs_cyc[0] : -1;
    check("t2_tile0_span", 64'(g), 64'd15);
    g = (hs_cyc.size() >= 32) ? hs_cyc[16] - hs_cyc[15] : -1;
    check("t2_bubble", 64'(g), 64'd2);
    g = (hs_cyc.size() >= 32) ? hs_cyc[31] - hs_cyc[16] : -1;
    check("t2_tile1_span", 64'(g), 64'd15);

    // 3: consumer stalled; words 33..48 dropped, overflow sticky
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 48; i++) begin
      send(gen_word(3 + i / 16, i % 16), i < 32);
      check("t3_inhibit", 64'(inhibit), 64'(i >= 31));
    end
    check("t3_overflow", 64'(overflow), 64'd1);
    check("t3_valid_stalled", 64'(out_valid), 64'd1);
    check("t3_none_yet", 64'(delivered), 64'd0);
    out_ready = 1'b1;
    wait_drained("t3_drain_timeout", 200);
    check("t3_count", 64'(delivered), 64'd32);
    check("t3_tile", 64'(out_tile), 64'd2);
    check("t3_overflow_sticky", 64'(overflow), 64'd1);
    check("t3_inhibit_free", 64'(inhibit), 64'd0);

    // 4: out_ready toggling every cycle while one tile streams
    do_reset();
    n_stall = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(gen_word(6, i), 1'b1);
      end
      begin
        for (int c = 0; c < 80; c++) begin
          out_ready = (c % 2 == 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drained("t4_drain_timeout", 50);
    check("t4_count", 64'(delivered), 64'd16);
    check("t4_tile", 64'(out_tile), 64'd1);
    check("t4_stalls_seen", 64'(n_stall >= 8), 64'd1);

    // 5: reset with a stalled tile and a partial tile in flight
    out_ready = 1'b0;
    for (int i = 0; i < 23; i++) send(gen_word(7 + i / 16, i % 16), 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    check("t5_pre_valid", 64'(out_valid), 64'd1);
    check("t5_pre_tile", 64'(out_tile), 64'd1);
    check("t5_pre_outD", outD, gen_word(7, 0));
    #2;
    reset = 1'b1;
    exp_q.delete();
    hs_cyc.delete();
    #1;
    check_zero_outputs("t5_async");
    @(posedge clk); #1;
    reset     = 1'b0;
    delivered = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(gen_word(9, i), 1'b1);
    wait_drained("t5_drain_timeout", 100);
    check("t5_count", 64'(delivered), 64'd16);
    check("t5_tile", 64'(out_tile), 64'd1);
    check("t5_overflow", 64'(overflow), 64'd0);

    // 6: word arrives for a full bank on the cycle that bank is released
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) send(gen_word(10 + i / 16, i % 16), 1'b1);
    check("t6_both_full", 64'(inhibit), 64'd1);
    out_ready = 1'b1;
    n = 0;
    while (!(out_valid && out_addr == 4'd15) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_reach_last_timeout", 64'(n >= 100), 64'd0);
    check("t6_inhibit_at_release", 64'(inhibit), 64'd1);
    send(gen_word(12, 0), 1'b1);
    check("t6_overflow", 64'(overflow), 64'd0);
    check("t6_inhibit_after", 64'(inhibit), 64'd0);
    for (int i = 1; i < 16; i++) send(gen_word(12, i), 1'b1);
    wait_drained("t6_drain_timeout", 200);
    check("t6_count", 64'(delivered), 64'd48);
    check("t6_tile", 64'(out_tile), 64'd3);
    check("t6_overflow_end", 64'(overflow), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fw_tile_drain.md
Name: fw_tile_drain

Overview:
- Receiving end of the fw core's output stream.
- Captures 64-bit result words (4 x 16-bit distance elements per word) from fw outD/out_valid into a ping-pong pair of 8x8-tile buffers.
- Streams each complete tile to a downstream consumer over a valid/ready handshake.
- Throttles fw through inhibit when no buffer is free.

Parameters:
- DATA_W, 64, width of one stream word.
- ELEM_W, 16, width of one distance element (DATA_W/ELEM_W = 4 elements per word).
- WORDS_PER_TILE, 16, words per 8x8 tile (8 rows x 2 words).
- TILE_CNT_W, 8, width of the tile counter.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- inD  in  DATA_W  result word from fw (fw outD).
- in_valid  in  1  inD valid this cycle (fw out_valid).
- inhibit  out  1  stall request to fw; high while the write bank is full.
- outD  out  DATA_W  tile word to consumer.
- out_valid  out  1  outD holds a valid word.
- out_ready  in  1  consumer accepts outD this cycle.
- out_last  out  1  outD is word WORDS_PER_TILE-1 of its tile.
- out_addr  out  4  word index of outD within its tile (0..15).
- out_tile  out  TILE_CNT_W  count of tiles fully delivered.
- overflow  out  1  sticky; a word arrived with no free bank.

Behaviour:
- Reset values: inhibit=0, outD=0, out_valid=0, out_last=0, out_addr=0, out_tile=0, overflow=0. Both bank-full flags clear, wr_bank=0, rd_bank=0, wr_ptr=0. A partial tile in progress at reset is discarded.
- Write side:
  - When in_valid=1 and full[wr_bank]=0, write inD to bank[wr_bank][wr_ptr] and increment wr_ptr.
  - On the write at wr_ptr=15: set full[wr_bank], toggle wr_bank, set wr_ptr=0.
- inhibit = full[wr_bank], driven from registers with no combinational path from inputs.
- Drop rule: if in_valid=1 while full[wr_bank]=1 and that bank is not being released in the same cycle, the word is dropped and overflow is set. overflow stays set until reset.
- Simultaneous release: if the reader hands off word 15 of bank B in the same cycle a word arrives for B, the word is accepted into B at address 0. The write is valid because the release clears full[B] that edge.
- Read FSM states:
  - IDLE → LOAD when full[rd_bank]=1.
  - LOAD issues the read of address 0 → STREAM.
  - STREAM: on each out_valid && out_ready handshake, out_addr increments and the next address is prefetched.
  - On a handshake with out_last=1: clear full[rd_bank], toggle rd_bank, increment out_tile (wraps modulo 2^TILE_CNT_W). Go to LOAD if the other bank is full, else IDLE.
- Latency: out_valid rises 2 cycles after the edge that writes word 15 (LOAD cycle plus registered RAM read).
- Throughput: one word per cycle while out_ready=1. Between back-to-back tiles there is a single-cycle bubble (the LOAD state).
- Hold rule: while out_valid=1 and out_ready=0, outD, out_addr and out_last are held stable.
- out_last = (out_addr==15) && out_valid.
- Data passes through unmodified; element order within a word and word order within a tile are preserved.

Decomposition:
- Package fw_pkg:
  - constants DATA_W, ELEM_W, TILE_DIM=8, WORDS_PER_TILE;
  - typedef fw_word_t (logic [DATA_W-1:0]);
  - enum drain_state_t {IDLE, LOAD, STREAM}.
- Sub-module fw_tile_bank: 2 x 16 x 64 simple dual-port RAM with synchronous write and synchronous registered read, addressed by {bank, ptr}.

Test Plan:
1. One tile, out_ready=1: feed 16 words starting 64'h0061_0047_003f_0000, 64'h0055_001a_0006_0052, … → same 16 words out in order, out_addr 0..15, out_last only on word 15, out_tile 0→1, inhibit=0 throughout.
2. Two tiles back-to-back, out_ready=1: 32 continuous words → 32 words out, one bubble between tiles, out_tile=2, overflow=0.
3. Backpressure with out_ready=0: feed 48 words → inhibit rises after the edge accepting word 32. Words 33..48 are dropped and overflow=1. After releasing out_ready, exactly 32 words are delivered.
4. out_ready toggling 1,0,1,0: feed one tile → outD stable on every stalled cycle, no duplicate or missing words, out_tile=1.
5. Reset mid-tile: assert reset after word 7 is written → all outputs 0 asynchronously, before the next clock edge. Then feed a fresh 16-word tile → clean delivery, out_tile=1.
6. Simultaneous release: both banks full, and in_valid arrives on the cycle word 15 of rd_bank is handshaken → word accepted at address 0, overflow stays 0.
